// File: rtl/register_em_ctl.sv
// Execute->Memory pipeline register with stall, flush, valid bit, lane mask and vector data.
// Optional stall/flush performance counters are built when EM_PERF_CNT_EN is defined.
module register_em_ctl #(
   parameter int N     = 24,
   parameter int LANES = 1,
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 StallM,
   input  logic                 FlushM,
   input  logic                 ValidE,
   input  logic                 PCSrcE_cond,
   input  logic                 RegWriteE_cond,
   input  logic                 MemtoRegE,
   input  logic                 MemWriteE_cond,
   input  logic [LANES-1:0]     LaneMaskE,
   input  logic [LANES*N-1:0]   ALUResultE,
   input  logic [LANES*N-1:0]   WriteDataE,
   input  logic [RA_W-1:0]      WA3E,
   output logic                 ValidM,
   output logic                 PCSrcM,
   output logic                 RegWriteM,
   output logic                 MemtoRegM,
   output logic                 MemWriteM,
   output logic [LANES-1:0]     LaneMaskM,
   output logic [LANES*N-1:0]   ALUResultM,
   output logic [LANES*N-1:0]   WriteDataM,
   output logic [RA_W-1:0]      WA3M,
   input  logic                 perf_clr,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   // Control fields are cleared by a flush; data fields only ever load or hold.
   typedef struct packed {
      logic             valid;
      logic             pcsrc;
      logic             regwrite;
      logic             memtoreg;
      logic             memwrite;
      logic [LANES-1:0] lane_mask;
   } ctrl_t;

   typedef struct packed {
      logic [LANES*N-1:0] alu_result;
      logic [LANES*N-1:0] write_data;
      logic [RA_W-1:0]    wa3;
   } data_t;

   ctrl_t ctrl_q, ctrl_d;
   data_t data_q, data_d;

   // NOTE: every field gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (FlushM) begin
         ctrl_d = '0;
      end else if (!StallM) begin
         ctrl_d.valid     = ValidE;
         ctrl_d.pcsrc     = ValidE & PCSrcE_cond;
         ctrl_d.regwrite  = ValidE & RegWriteE_cond;
         ctrl_d.memtoreg  = ValidE & MemtoRegE;
         ctrl_d.memwrite  = ValidE & MemWriteE_cond;
         ctrl_d.lane_mask = ValidE ? LaneMaskE : '0;
         data_d.alu_result = ALUResultE;
         data_d.write_data = WriteDataE;
         data_d.wa3        = WA3E;
      end
   end

   // NOTE: the data fields are reset as well, even though ValidM=0 already marks them unused,
   // so that every output reads 0 while rst_n is low.
   // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end
   end

   assign ValidM     = ctrl_q.valid;
   assign PCSrcM     = ctrl_q.pcsrc;
   assign RegWriteM  = ctrl_q.regwrite;
   assign MemtoRegM  = ctrl_q.memtoreg;
   assign MemWriteM  = ctrl_q.memwrite;
   assign LaneMaskM  = ctrl_q.lane_mask;
   assign ALUResultM = data_q.alu_result;
   assign WriteDataM = data_q.write_data;
   assign WA3M       = data_q.wa3;

`ifdef EM_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Counters saturate instead of wrapping; a clear wins over a same-cycle increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (StallM && !FlushM && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
         if (FlushM && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_perf_clr;

   assign unused_perf_clr = perf_clr;
   assign stall_cnt       = '0;
   assign flush_cnt       = '0;
`endif

endmodule
